// File: rtl/car_motion_controller.sv
// car_motion_controller
// Per-car sequencer that sits upstream of the prioritizer. It accepts one target
// floor, moves the car one floor per TRAVEL_CYCLES, opens the door for
// DOOR_CYCLES, and then becomes ready again.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous, active-high reset
//   req_valid_i  target floor offered
//   req_floor_i  offered target floor
//   req_ready_o  controller can accept a target (high only in IDLE)
//   state_o      {floor[3:0], motion[1:0]}; 00 idle, 01 up, 10 down, 11 door open
//   floor_o      current floor
//   door_open_o  high while the door is open
//   arrived_o    one-cycle pulse on the cycle the door opens
//   req_err_o    one-cycle pulse after an out-of-range floor is accepted
//   door_hold_i  keeps the door open (only when CAR_DOOR_HOLD_EN is defined)
//
// Optional feature macro: CAR_DOOR_HOLD_EN

module car_motion_controller #(
    parameter int unsigned FLOORS        = 10,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
`ifdef CAR_DOOR_HOLD_EN
    input  logic       door_hold_i,
`endif
    input  logic       req_valid_i,
    input  logic [3:0] req_floor_i,
    output logic       req_ready_o,
    output logic [5:0] state_o,
    output logic [3:0] floor_o,
    output logic       door_open_o,
    output logic       arrived_o,
    output logic       req_err_o
);

    localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

    // Encoding doubles as the motion field of state_o.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        DOOR = 2'b11
    } fsm_e;

    fsm_e            state_q;
    logic [3:0]      floor_q;
    logic [3:0]      target_q;
    logic [TW-1:0]   timer_q;
    logic            door_open_q;
    logic            arrived_q;
    logic            req_err_q;
    logic [3:0]      next_floor_c;
    logic            out_of_range_c;

    // Floor reached at the end of the current travel interval.
    assign next_floor_c   = (state_q == UP) ? floor_q + 4'd1 : floor_q - 4'd1;
    assign out_of_range_c = {1'b0, req_floor_i} >= 5'(FLOORS);

    // Sequencer: state, floor, target, timer and registered status pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            floor_q     <= 4'd0;
            target_q    <= 4'd0;
            timer_q     <= '0;
            door_open_q <= 1'b0;
            arrived_q   <= 1'b0;
            req_err_q   <= 1'b0;
        end else begin
            arrived_q <= 1'b0;
            req_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (out_of_range_c) begin
                            req_err_q <= 1'b1;
                        end else if (req_floor_i == floor_q) begin
                            target_q    <= req_floor_i;
                            state_q     <= DOOR;
                            timer_q     <= DOOR_LOAD;
                            door_open_q <= 1'b1;
                            arrived_q   <= 1'b1;
                        end else begin
                            target_q <= req_floor_i;
                            timer_q  <= TRAVEL_LOAD;
                            state_q  <= (req_floor_i > floor_q) ? UP : DOWN;
                        end
                    end
                end
                UP, DOWN: begin
                    if (timer_q == '0) begin
                        floor_q <= next_floor_c;
                        if (next_floor_c == target_q) begin
                            state_q     <= DOOR;
                            timer_q     <= DOOR_LOAD;
                            door_open_q <= 1'b1;
                            arrived_q   <= 1'b1;
                        end else begin
                            timer_q <= TRAVEL_LOAD;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                DOOR: begin
`ifdef CAR_DOOR_HOLD_EN
                    if (door_hold_i) begin
                        timer_q <= DOOR_LOAD;
                    end else
`endif
                    if (timer_q == '0) begin
                        state_q     <= IDLE;
                        door_open_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    door_open_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign state_o     = {floor_q, state_q};
    assign floor_o     = floor_q;
    assign door_open_o = door_open_q;
    assign arrived_o   = arrived_q;
    assign req_err_o   = req_err_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// Self-checking bench for car_motion_controller (default parameters).
// Stimulus tasks push expected arrived/req_err events into a queue; a monitor
// pops and compares whenever the DUT pulses one of them. Motion and door
// timing are also checked cycle by cycle against hand-derived values.

module tb_car_motion_controller;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_floor;
    logic       req_ready;
    logic [5:0] state;
    logic [3:0] floor;
    logic       door_open;
    logic       arrived;
    logic       req_err;
`ifdef CAR_DOOR_HOLD_EN
    logic       door_hold;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         kind;   // 0 arrived, 1 req_err
        logic [5:0] st;
        int         at;
    } ev_t;

    ev_t exp_q[$];

    car_motion_controller dut (
        .clk_i       (clk),
        .reset_i     (reset),
`ifdef CAR_DOOR_HOLD_EN
        .door_hold_i (door_hold),
`endif
        .req_valid_i (req_valid),
        .req_floor_i (req_floor),
        .req_ready_o (req_ready),
        .state_o     (state),
        .floor_o     (floor),
        .door_open_o (door_open),
        .arrived_o   (arrived),
        .req_err_o   (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every event pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset && (arrived || req_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, req_err, arrived}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_kind", {31'd0, req_err}, 32'(e.kind));
                chk("event_both", {31'd0, arrived & req_err}, 32'd0);
                chk("event_state", {26'd0, state}, {26'd0, e.st});
                chk("event_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic push_ev(input int kind, input logic [5:0] st, input int at);
        ev_t e;
        e.kind = kind;
        e.st   = st;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Accept a target and verify travel, door and return to IDLE.
    // interfere_k >= 0 offers floor 9 during that travel cycle (must be ignored).
    task automatic run_move(input int target, input int from, input int interfere_k, input bit hold);
        int n, lat, door_len, fl;
        logic [1:0] mv;
        n        = (target > from) ? target - from : from - target;
        lat      = n * 4;
        mv       = (target > from) ? 2'b01 : 2'b10;
        door_len = hold ? 16 : 8;
        @(negedge clk);
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_floor = 4'(target);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        push_ev(0, {4'(target), 2'b11}, cyc + lat);
        for (int k = 0; k < lat; k++) begin
            fl = (target > from) ? from + k / 4 : from - k / 4;
            chk("move_state", {26'd0, state}, {26'd0, 4'(fl), mv});
            chk("move_ready", {31'd0, req_ready}, 32'd0);
            if (k == interfere_k) begin
                req_valid = 1'b1;
                req_floor = 4'd9;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        for (int d = 0; d < door_len; d++) begin
            chk("door_state", {26'd0, state}, {26'd0, 4'(target), 2'b11});
            chk("door_open", {31'd0, door_open}, 32'd1);
            chk("door_ready", {31'd0, req_ready}, 32'd0);
`ifdef CAR_DOOR_HOLD_EN
            door_hold = hold && (d >= 3) && (d <= 7);
`endif
            @(posedge clk);
            #1;
        end
`ifdef CAR_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        chk("closed_state", {26'd0, state}, {26'd0, 4'(target), 2'b00});
        chk("closed_ready", {31'd0, req_ready}, 32'd1);
        chk("closed_door", {31'd0, door_open}, 32'd0);
        chk("closed_floor", {28'd0, floor}, 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_floor = 4'd0;
`ifdef CAR_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_state", {26'd0, state}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_door", {31'd0, door_open}, 32'd0);
        chk("rst_arrived", {31'd0, arrived}, 32'd0);
        chk("rst_err", {31'd0, req_err}, 32'd0);

        run_move(3, 0, -1, 1'b0);
        run_move(7, 3, -1, 1'b0);
        run_move(2, 7, -1, 1'b0);
        run_move(5, 2, -1, 1'b0);
        run_move(5, 5, -1, 1'b0);

        // Out-of-range target in IDLE: error pulse only, no motion.
        @(negedge clk);
        req_valid = 1'b1;
        req_floor = 4'd12;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        push_ev(1, {4'd5, 2'b00}, cyc);
        chk("err_state", {26'd0, state}, {26'd0, 4'd5, 2'b00});
        chk("err_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("err_pulse_end", {31'd0, req_err}, 32'd0);
        chk("err_floor", {28'd0, floor}, 32'd5);

        // Offer while moving must be ignored.
        run_move(1, 5, 5, 1'b0);
        run_move(4, 1, -1, 1'b0);

        // Reset mid-move from floor 4 toward 8.
        @(negedge clk);
        req_valid = 1'b1;
        req_floor = 4'd8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_moving", {26'd0, state}, {26'd0, 4'd4, 2'b01});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_state", {26'd0, state}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_door", {31'd0, door_open}, 32'd0);
        run_move(1, 0, -1, 1'b0);

`ifdef CAR_DOOR_HOLD_EN
        run_move(3, 1, -1, 1'b1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
